hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Issue controller sitting between decode and execute. Keeps a register scoreboard
//  for long-latency writers (loads, multiplies) and stalls decode on RAW/WAW/structural
//  hazards. Sequences the shared multi-cycle multiplier: start pulse, latency count,
//  writeback pulse. Single-cycle ALU results are forwarded downstream and never tracked.
// PARAMETERS
//  XLEN     32  datapath width (kept for codebase uniformity; no datapath here)
//  NREG     32  architectural registers (5-bit specifiers); r0 hard-wired zero
//  MUL_LAT  4   multiplier latency in cycles, issue to writeback; legal range 2..15
// PORTS
//  clk          in   1   clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  D_valid      in   1   decode holds a valid instruction this cycle
//  D_ra         in   5   source A specifier
//  D_rb         in   5   source B specifier
//  D_rd         in   5   destination specifier
//  D_we         in   1   instruction writes D_rd
//  D_ld         in   1   instruction is a load
//  D_mul        in   1   instruction is a multiply
//  flush        in   1   kill the decode instruction this cycle (branch redirect)
//  ld_wb_valid  in   1   load data returns this cycle
//  ld_wb_rd     in   5   destination of returning load
//  stall        out  1   hold fetch/decode; = D_valid & hazard & ~flush
//  issue        out  1   instruction leaves decode; = D_valid & ~hazard & ~flush
//  mul_start    out  1   = issue & D_mul; multiplier latches operands
//  mul_wb       out  1   multiplier result valid; pulse, 1 cycle
//  mul_rd       out  5   destination for mul_wb; holds last value otherwise
//  pend_vec     out  32  scoreboard, bit i = register i awaiting long-latency write
// BEHAVIOUR
//  - Reset (async, rst_n=0): pend_vec=0, FSM=IDLE, cnt=0, mul_rd=0, mul_wb=0.
//    stall/issue/mul_start are combinational and follow their inputs.
//    In-flight mul is abandoned; mul_wb never fires for it.
//  - pend_eff = pend_vec with bit ld_wb_rd cleared if ld_wb_valid, and bit mul_rd
//    cleared if mul_wb. Hazards use pend_eff, so a consumer issues in its producer's
//    writeback cycle.
//  - hazard = pend_eff[D_ra] | pend_eff[D_rb] | (D_we & pend_eff[D_rd])
//    | (D_mul & mul_busy). All instructions check both ra and rb (conservative).
//  - mul_busy = (state==BUSY) & ~mul_wb. A new mul may issue in the mul_wb cycle.
//  - Scoreboard update at the clock edge: clear pend_eff bits, then set bit D_rd if
//    issue & D_we & (D_ld|D_mul) & D_rd!=0. Set wins over clear on the same bit.
//    Bit 0 is always 0.
//  - Mul FSM, IDLE/BUSY, cnt width 4. IDLE: mul_start -> BUSY, cnt<=MUL_LAT,
//    mul_rd<=D_rd. BUSY: cnt decrements each cycle; mul_wb=1 when cnt==1.
//    On mul_wb: mul_start -> stay BUSY and reload; else -> IDLE.
//  - Latency: mul issued in cycle t gives mul_wb in cycle t+MUL_LAT.
//    Load latency is external, ended by ld_wb_valid.
//  - ld_wb and mul_wb in the same cycle: both bits clear. Same rd on both is
//    impossible by the WAW rule.
//  - flush: suppresses issue and stall only. The scoreboard and in-flight mul are
//    untouched; older ops still write back.
//  - ld_wb_valid for a non-pending register is ignored; it is not an error.
// CONFIGURATION
//  HAZARD_STATS_EN defined: adds outputs raw_stall_cnt, waw_stall_cnt, mul_stall_cnt.
//    Each is 16 bits, saturating at 0xFFFF, cleared by rst_n. Each increments once per
//    stall cycle by priority RAW > WAW > structural.
//  HAZARD_STATS_EN undefined: these ports and counters do not exist; all other
//    behaviour is identical.
// TESTING
//  1. ld r3 issue; then add rd=4 ra=3 -> stall=1 until ld_wb_valid rd=3;
//     issue=1 in that same cycle; pend_vec[3] 1->0.
//  2. MUL_LAT=4, mul rd=5 at t -> mul_start@t, mul_wb@t+4 with mul_rd=5;
//     a second mul presented at t+1 stalls t+1..t+3 and issues at t+4.
//  3. ld rd=0 issue -> pend_vec stays 0; next add ra=0 issues with no stall.
//  4. mul rd=7 issued, rst_n=0 at t+2 -> pend_vec=0, FSM IDLE; no mul_wb at t+4.
//  5. ld rd=2 and mul rd=6 pending; ld_wb rd=2 and mul_wb in the same cycle ->
//     pend_vec[2]=pend_vec[6]=0 next cycle.
//  6. Hazarded add with flush=1 -> stall=0, issue=0; pend_vec unchanged.
//     With HAZARD_STATS_EN, test 1 gives raw_stall_cnt equal to the stall cycles counted.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - decode, writeback and scoreboard signal bundle for hazard_ctrl (HAZARD_STATS_EN adds stall counters)
interface hazard_ctrl_if;
   logic        D_valid;
   logic [4:0]  D_ra;
   logic [4:0]  D_rb;
   logic [4:0]  D_rd;
   logic        D_we;
   logic        D_ld;
   logic        D_mul;
   logic        flush;
   logic        ld_wb_valid;
   logic [4:0]  ld_wb_rd;
   logic        stall;
   logic        issue;
   logic        mul_start;
   logic        mul_wb;
   logic [4:0]  mul_rd;
   logic [31:0] pend_vec;
`ifdef HAZARD_STATS_EN
   logic [15:0] raw_stall_cnt;
   logic [15:0] waw_stall_cnt;
   logic [15:0] mul_stall_cnt;

   modport master (
      output D_valid, D_ra, D_rb, D_rd, D_we, D_ld, D_mul, flush, ld_wb_valid, ld_wb_rd,
      input  stall, issue, mul_start, mul_wb, mul_rd, pend_vec,
      input  raw_stall_cnt, waw_stall_cnt, mul_stall_cnt
   );
   modport slave (
      input  D_valid, D_ra, D_rb, D_rd, D_we, D_ld, D_mul, flush, ld_wb_valid, ld_wb_rd,
      output stall, issue, mul_start, mul_wb, mul_rd, pend_vec,
      output raw_stall_cnt, waw_stall_cnt, mul_stall_cnt
   );
`else
   modport master (
      output D_valid, D_ra, D_rb, D_rd, D_we, D_ld, D_mul, flush, ld_wb_valid, ld_wb_rd,
      input  stall, issue, mul_start, mul_wb, mul_rd, pend_vec
   );
   modport slave (
      input  D_valid, D_ra, D_rb, D_rd, D_we, D_ld, D_mul, flush, ld_wb_valid, ld_wb_rd,
      output stall, issue, mul_start, mul_wb, mul_rd, pend_vec
   );
`endif
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - issue controller: long-latency scoreboard, hazard stall, multiplier sequencer (HAZARD_STATS_EN adds stall counters)
module hazard_ctrl #(
   parameter int XLEN    = 32,
   parameter int NREG    = 32,
   parameter int MUL_LAT = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   hazard_ctrl_if.slave bus
);

   if (XLEN < 1 || NREG != 32 || MUL_LAT < 2 || MUL_LAT > 15) begin : g_param_check
      $error("hazard_ctrl: illegal parameter value");
   end

   localparam logic [3:0] LAT = 4'(MUL_LAT);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t          state, state_nx;
   logic [3:0]      cnt, cnt_nx;
   logic [4:0]      mul_rd_q, mul_rd_nx;
   logic [NREG-1:0] pend_q, pend_eff, pend_nx;
   logic            mul_wb;
   logic            mul_busy;
   logic            raw_hz, waw_hz, str_hz, hazard;
   logic            issue, stall, mul_start;

   assign mul_wb   = (state == BUSY) && (cnt == 4'd1);
   assign mul_busy = (state == BUSY) && !mul_wb;

   // Scoreboard as seen this cycle: writebacks landing now no longer block consumers
   always_comb begin
      pend_eff = pend_q;
      if (bus.ld_wb_valid) pend_eff[bus.ld_wb_rd] = 1'b0;
      if (mul_wb)          pend_eff[mul_rd_q]     = 1'b0;
   end

   assign raw_hz    = pend_eff[bus.D_ra] | pend_eff[bus.D_rb];
   assign waw_hz    = bus.D_we & pend_eff[bus.D_rd];
   assign str_hz    = bus.D_mul & mul_busy;
   assign hazard    = raw_hz | waw_hz | str_hz;
   assign stall     = bus.D_valid & hazard & ~bus.flush;
   assign issue     = bus.D_valid & ~hazard & ~bus.flush;
   assign mul_start = issue & bus.D_mul;

   // Next scoreboard: clear landing writebacks, then mark the new long-latency destination
   always_comb begin
      pend_nx = pend_eff;
      if (issue && bus.D_we && (bus.D_ld || bus.D_mul) && (bus.D_rd != 5'd0))
         pend_nx[bus.D_rd] = 1'b1;
      pend_nx[0] = 1'b0;
   end

   // Scoreboard register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pend_q <= '0;
      else        pend_q <= pend_nx;
   end

   // Multiplier sequencer next state: count down from issue, allow back-to-back reload on writeback
   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      mul_rd_nx = mul_rd_q;
      case (state)
         IDLE: begin
            if (mul_start) begin
               state_nx  = BUSY;
               cnt_nx    = LAT;
               mul_rd_nx = bus.D_rd;
            end
         end
         BUSY: begin
            if (mul_wb) begin
               if (mul_start) begin
                  cnt_nx    = LAT;
                  mul_rd_nx = bus.D_rd;
               end else begin
                  state_nx = IDLE;
                  cnt_nx   = 4'd0;
               end
            end else begin
               cnt_nx = cnt - 4'd1;
            end
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = 4'd0;
         end
      endcase
   end

   // Multiplier sequencer state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= 4'd0;
         mul_rd_q <= 5'd0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         mul_rd_q <= mul_rd_nx;
      end
   end

   assign bus.stall     = stall;
   assign bus.issue     = issue;
   assign bus.mul_start = mul_start;
   assign bus.mul_wb    = mul_wb;
   assign bus.mul_rd    = mul_rd_q;
   assign bus.pend_vec  = pend_q;

`ifdef HAZARD_STATS_EN
   logic [15:0] raw_cnt, waw_cnt, mul_cnt;

   // Stall cause counters, one bucket per stall cycle, RAW before WAW before structural
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         raw_cnt <= 16'd0;
         waw_cnt <= 16'd0;
         mul_cnt <= 16'd0;
      end else if (stall) begin
         if (raw_hz) begin
            if (raw_cnt != 16'hFFFF) raw_cnt <= raw_cnt + 16'd1;
         end else if (waw_hz) begin
            if (waw_cnt != 16'hFFFF) waw_cnt <= waw_cnt + 16'd1;
         end else begin
            if (mul_cnt != 16'hFFFF) mul_cnt <= mul_cnt + 16'd1;
         end
      end
   end

   assign bus.raw_stall_cnt = raw_cnt;
   assign bus.waw_stall_cnt = waw_cnt;
   assign bus.mul_stall_cnt = mul_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - vector table, directed reset sequence and randomized model check for hazard_ctrl
module tb_hazard_ctrl;
   localparam int MUL_LAT = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   hazard_ctrl_if hif ();

   hazard_ctrl #(.XLEN(32), .NREG(32), .MUL_LAT(MUL_LAT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (hif)
   );

   typedef struct {
      logic v; logic [4:0] ra, rb, rd; logic we, ld, mul, fl, ldv; logic [4:0] ldrd;
      logic e_stall, e_issue, e_start, e_wb; logic [4:0] e_mrd; logic [31:0] e_pend;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic v, logic [4:0] ra, logic [4:0] rb, logic [4:0] rd,
                               logic we, logic ld, logic mul, logic fl, logic ldv, logic [4:0] ldrd,
                               logic st, logic is, logic ms, logic wb, logic [4:0] mrd, logic [31:0] pend);
      vec_t r;
      r.v = v; r.ra = ra; r.rb = rb; r.rd = rd; r.we = we; r.ld = ld; r.mul = mul; r.fl = fl;
      r.ldv = ldv; r.ldrd = ldrd; r.e_stall = st; r.e_issue = is; r.e_start = ms; r.e_wb = wb;
      r.e_mrd = mrd; r.e_pend = pend;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input vec_t r);
      hif.D_valid = r.v; hif.D_ra = r.ra; hif.D_rb = r.rb; hif.D_rd = r.rd;
      hif.D_we = r.we; hif.D_ld = r.ld; hif.D_mul = r.mul; hif.flush = r.fl;
      hif.ld_wb_valid = r.ldv; hif.ld_wb_rd = r.ldrd;
   endtask

   task automatic check_row(input string tag, input vec_t r);
      chk({tag, " stall"},     32'(hif.stall),     32'(r.e_stall));
      chk({tag, " issue"},     32'(hif.issue),     32'(r.e_issue));
      chk({tag, " mul_start"}, 32'(hif.mul_start), 32'(r.e_start));
      chk({tag, " mul_wb"},    32'(hif.mul_wb),    32'(r.e_wb));
      chk({tag, " mul_rd"},    32'(hif.mul_rd),    32'(r.e_mrd));
      chk({tag, " pend_vec"},  hif.pend_vec,       r.e_pend);
   endtask

   // Reference model state: absolute completion time for the multiplier, bit sets for pending regs
   logic [31:0] m_pend, m_ldpend;
   bit          m_act;
   int          m_done, cyc;
   logic [4:0]  m_mrd;

   initial begin
      vec_t idle, r;
      idle = mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0);
      drive(idle);

      // Directed rows: load RAW, mul latency/structural, load+mul coincident writeback, r0 load, flush
      tbl.push_back(mk(1,0,0,3,1,1,0,0,0,0, 0,1,0,0,0,32'h0));
      tbl.push_back(mk(1,3,0,4,1,0,0,0,0,0, 1,0,0,0,0,32'h8));
      tbl.push_back(mk(1,3,0,4,1,0,0,0,0,0, 1,0,0,0,0,32'h8));
      tbl.push_back(mk(1,3,0,4,1,0,0,0,1,3, 0,1,0,0,0,32'h8));
      tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,32'h0));
      tbl.push_back(mk(1,1,2,5,1,0,1,0,0,0, 0,1,1,0,0,32'h0));
      for (int i = 0; i < 3; i++)
         tbl.push_back(mk(1,1,2,6,1,0,1,0,0,0, 1,0,0,0,5,32'h20));
      tbl.push_back(mk(1,1,2,6,1,0,1,0,0,0, 0,1,1,1,5,32'h20));
      tbl.push_back(mk(1,0,0,2,1,1,0,0,0,0, 0,1,0,0,6,32'h40));
      tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,6,32'h44));
      tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,6,32'h44));
      tbl.push_back(mk(0,0,0,0,0,0,0,0,1,2, 0,0,0,1,6,32'h44));
      tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,6,32'h0));
      tbl.push_back(mk(1,0,0,0,1,1,0,0,0,0, 0,1,0,0,6,32'h0));
      tbl.push_back(mk(1,0,0,1,1,0,0,0,0,0, 0,1,0,0,6,32'h0));
      tbl.push_back(mk(1,0,0,9,1,1,0,0,0,0, 0,1,0,0,6,32'h0));
      tbl.push_back(mk(1,9,0,10,1,0,0,1,0,0, 0,0,0,0,6,32'h200));
      tbl.push_back(mk(1,9,0,10,1,0,0,0,0,0, 1,0,0,0,6,32'h200));
      tbl.push_back(mk(0,0,0,0,0,0,0,0,1,9, 0,0,0,0,6,32'h200));
      tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,6,32'h0));

      // Reset state; combinational issue still follows inputs while in reset
      #1;
      check_row("reset", idle);
      r = mk(1,1,2,3,1,0,0,0,0,0, 0,1,0,0,0,32'h0);
      drive(r);
      #1;
      chk("reset issue follows", 32'(hif.issue), 32'd1);
      drive(idle);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      foreach (tbl[i]) begin
         drive(tbl[i]);
         #1;
         check_row($sformatf("row%0d", i), tbl[i]);
         @(posedge clk); #1;
      end
      drive(idle);

`ifdef HAZARD_STATS_EN
      chk("raw_stall_cnt", 32'(hif.raw_stall_cnt), 32'd3);
      chk("waw_stall_cnt", 32'(hif.waw_stall_cnt), 32'd0);
      chk("mul_stall_cnt", 32'(hif.mul_stall_cnt), 32'd3);
`endif

      // Reset abandons an in-flight multiply
      r = mk(1,0,0,7,1,0,1,0,0,0, 0,1,1,0,6,32'h0);
      drive(r);
      #1;
      check_row("rst_mul issue", r);
      @(posedge clk); #1;
      drive(idle);
      #1;
      chk("rst_mul pend7", hif.pend_vec, 32'h80);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("rst_mul pend cleared", hif.pend_vec, 32'h0);
      chk("rst_mul mul_rd", 32'(hif.mul_rd), 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk($sformatf("rst_mul no wb %0d", i), 32'(hif.mul_wb), 32'd0);
         chk($sformatf("rst_mul pend %0d", i), hif.pend_vec, 32'h0);
         @(posedge clk); #1;
      end

      // Randomized traffic against a time-based model
      m_pend = '0; m_ldpend = '0; m_act = 0; m_done = 0; m_mrd = '0; cyc = 0;
      for (int c = 0; c < 600; c++) begin
         logic [31:0] eff;
         bit          m_wb, busy, hz, e_is, e_st, e_ms;
         int          j;
         r = idle;
         r.v   = ($urandom_range(0, 9) < 8);
         r.ra  = 5'($urandom_range(0, 7));
         r.rb  = 5'($urandom_range(0, 7));
         r.rd  = 5'($urandom_range(0, 7));
         case ($urandom_range(0, 3))
            0: r.ld = 1'b1;
            1: r.mul = 1'b1;
            default: ;
         endcase
         r.we = r.ld | r.mul | 1'($urandom_range(0, 1));
         r.fl = ($urandom_range(0, 9) == 0);
         if (m_ldpend != 0 && $urandom_range(0, 2) == 0) begin
            do j = $urandom_range(0, 7); while (!m_ldpend[j]);
            r.ldv = 1'b1; r.ldrd = 5'(j);
         end else if ($urandom_range(0, 9) == 0) begin
            j = $urandom_range(0, 7);
            if (!m_pend[j]) begin r.ldv = 1'b1; r.ldrd = 5'(j); end
         end

         m_wb = m_act && (cyc == m_done);
         eff  = m_pend;
         if (r.ldv) eff[r.ldrd] = 1'b0;
         if (m_wb)  eff[m_mrd]  = 1'b0;
         busy = m_act && !m_wb;
         hz   = eff[r.ra] || eff[r.rb] || (r.we && eff[r.rd]) || (r.mul && busy);
         e_is = r.v && !hz && !r.fl;
         e_st = r.v && hz && !r.fl;
         e_ms = e_is && r.mul;
         r.e_stall = e_st; r.e_issue = e_is; r.e_start = e_ms; r.e_wb = m_wb;
         r.e_mrd = m_mrd; r.e_pend = m_pend;

         drive(r);
         #1;
         check_row($sformatf("rnd%0d", c), r);

         if (r.ldv) m_ldpend[r.ldrd] = 1'b0;
         if (m_wb) m_act = 0;
         if (e_ms) begin m_act = 1; m_done = cyc + MUL_LAT; m_mrd = r.rd; end
         m_pend = eff;
         if (e_is && r.we && (r.ld || r.mul) && r.rd != 0) begin
            m_pend[r.rd] = 1'b1;
            if (r.ld) m_ldpend[r.rd] = 1'b1;
         end
         cyc++;
         @(posedge clk); #1;
      end
      drive(idle);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
